// File: rtl/stack_cpu_pkg.sv
// rtl/stack_cpu_pkg.sv - opcode/state enums, error codes and instruction field helpers
// Instructions are {opcode[3:0], operand[OPND_W-1:0]}. The field helpers take the
// instruction zero-extended to MAX_IW bits so one function serves any OPND_W.
package stack_cpu_pkg;

    typedef enum logic [3:0] {
        OP_PUSH  = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_JMPF  = 4'd5,
        OP_JMPB  = 4'd6,
        OP_BEQ   = 4'd7,
        OP_BNE   = 4'd8,
        OP_BLE   = 4'd9,
        OP_BGT   = 4'd10,
        OP_DUP   = 4'd11,
        OP_HALT  = 4'd12
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    localparam int MAX_IW = 64;

    function automatic opcode_e instr_opcode(input logic [MAX_IW-1:0] instr, input int opnd_w);
        logic [MAX_IW-1:0] sh;
        sh = instr >> opnd_w;
        return opcode_e'(sh[3:0]);
    endfunction

    function automatic logic [MAX_IW-1:0] instr_operand(input logic [MAX_IW-1:0] instr, input int opnd_w);
        logic [MAX_IW-1:0] mask;
        mask = {MAX_IW{1'b1}} << opnd_w;
        return instr & ~mask;
    endfunction

    // Encodings 13..15 have no enum member and are illegal.
    function automatic logic op_illegal(input opcode_e op);
        return op > OP_HALT;
    endfunction

    // Number of stack entries the instruction must find before it may commit.
    function automatic logic [1:0] op_need(input opcode_e op);
        case (op)
            OP_STORE, OP_DUP:                               return 2'd1;
            OP_ADD, OP_SUB, OP_BEQ, OP_BNE, OP_BLE, OP_BGT: return 2'd2;
            default:                                        return 2'd0;
        endcase
    endfunction

    function automatic logic op_pushes(input opcode_e op);
        return (op == OP_PUSH) || (op == OP_LOAD) || (op == OP_DUP);
    endfunction

endpackage

// File: rtl/stack_cpu_stack.sv
// rtl/stack_cpu_stack.sv - operand stack register file, T/S read ports, one write port
// Ports: clk; sp (entry count from parent); we/waddr/wdata write port;
// t_data = stack[sp-1], s_data = stack[sp-2] (undefined contents when sp is too small).
module stack_cpu_stack
    import stack_cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int STACK_AW = 4
) (
    input  logic                clk,
    input  logic [STACK_AW:0]   sp,
    input  logic                we,
    input  logic [STACK_AW-1:0] waddr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   t_data,
    output logic [DATA_W-1:0]   s_data
);

    localparam int SP_W = STACK_AW + 1;

    logic [DATA_W-1:0]   mem [0:(1<<STACK_AW)-1];
    logic [STACK_AW-1:0] t_idx;
    logic [STACK_AW-1:0] s_idx;

    assign t_idx  = STACK_AW'(sp - SP_W'(1));
    assign s_idx  = STACK_AW'(sp - SP_W'(2));
    assign t_data = mem[t_idx];
    assign s_data = mem[s_idx];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/stack_cpu.sv
// rtl/stack_cpu.sv - single-cycle stack processor with run/halt/error control
// Ports: clk, rst_n (async, active-high); start; imem_we/imem_waddr/imem_wdata program load;
// dmem_raddr/dmem_rdata host readback; busy/done/error status; err_code; pc_o; tos; retired.
module stack_cpu
    import stack_cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int OPND_W   = 8,
    parameter int IMEM_AW  = 8,
    parameter int DMEM_AW  = 8,
    parameter int STACK_AW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                imem_we,
    input  logic [IMEM_AW-1:0]  imem_waddr,
    input  logic [4+OPND_W-1:0] imem_wdata,
    input  logic [DMEM_AW-1:0]  dmem_raddr,
    output logic [DATA_W-1:0]   dmem_rdata,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [IMEM_AW-1:0]  pc_o,
    output logic [DATA_W-1:0]   tos,
    output logic [15:0]         retired
);

    localparam int IW   = 4 + OPND_W;
    localparam int SP_W = STACK_AW + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(1 << STACK_AW);

    logic [IW-1:0]     imem [0:(1<<IMEM_AW)-1];
    logic [DATA_W-1:0] dmem [0:(1<<DMEM_AW)-1];

    state_e            state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [15:0]       retired_q, retired_d;
    logic [1:0]        err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [IW-1:0]      instr;
    opcode_e            op;
    logic [IMEM_AW-1:0] imm_pc;
    logic [DMEM_AW-1:0] imm_dm;
    logic [DATA_W-1:0]  imm_dat;
    logic [IMEM_AW-1:0] pc_inc;

    logic [DATA_W-1:0]   t_data, s_data;
    logic                stk_we;
    logic [STACK_AW-1:0] stk_waddr;
    logic [DATA_W-1:0]   stk_wdata;
    logic                dm_we;
    logic [DMEM_AW-1:0]  dm_waddr;
    logic [DATA_W-1:0]   dm_wdata;
    logic [1:0]          trap;
    logic                br_taken;

    assign instr   = imem[pc_q];
    assign op      = instr_opcode(MAX_IW'(instr), OPND_W);
    assign imm_pc  = IMEM_AW'(instr_operand(MAX_IW'(instr), OPND_W));
    assign imm_dm  = DMEM_AW'(instr_operand(MAX_IW'(instr), OPND_W));
    assign imm_dat = DATA_W'(instr_operand(MAX_IW'(instr), OPND_W));
    assign pc_inc  = pc_q + IMEM_AW'(1);

    stack_cpu_stack #(
        .DATA_W   (DATA_W),
        .STACK_AW (STACK_AW)
    ) u_stack (
        .clk    (clk),
        .sp     (sp_q),
        .we     (stk_we),
        .waddr  (stk_waddr),
        .wdata  (stk_wdata),
        .t_data (t_data),
        .s_data (s_data)
    );

    always_comb begin
        br_taken = 1'b0;
        case (op)
            OP_BEQ:  br_taken = (s_data == t_data);
            OP_BNE:  br_taken = (s_data != t_data);
            OP_BLE:  br_taken = (s_data <= t_data);
            OP_BGT:  br_taken = (s_data >  t_data);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        retired_d = retired_q;
        err_d     = err_q;
        trap      = ERR_NONE;
        stk_we    = 1'b0;
        stk_waddr = '0;
        stk_wdata = '0;
        dm_we     = 1'b0;
        dm_waddr  = '0;
        dm_wdata  = '0;

        if (state_q == ST_RUN) begin
            // Trap checks gate every side effect of the instruction.
            if (op_illegal(op)) begin
                trap = ERR_ILLEGAL;
            end else if (sp_q < SP_W'(op_need(op))) begin
                trap = ERR_UNDERFLOW;
            end else if (op_pushes(op) && (sp_q == SP_FULL)) begin
                trap = ERR_OVERFLOW;
            end

            if (trap != ERR_NONE) begin
                state_d = ST_ERROR;
                err_d   = trap;
            end else begin
                retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
                pc_d      = pc_inc;
                case (op)
                    OP_PUSH: begin
                        stk_we    = 1'b1;
                        stk_waddr = STACK_AW'(sp_q);
                        stk_wdata = imm_dat;
                        sp_d      = sp_q + SP_W'(1);
                    end
                    OP_LOAD: begin
                        stk_we    = 1'b1;
                        stk_waddr = STACK_AW'(sp_q);
                        stk_wdata = dmem[imm_dm];
                        sp_d      = sp_q + SP_W'(1);
                    end
                    OP_STORE: begin
                        dm_we    = 1'b1;
                        dm_waddr = imm_dm;
                        dm_wdata = t_data;
                        sp_d     = sp_q - SP_W'(1);
                    end
                    OP_ADD, OP_SUB: begin
                        // Result overwrites S in place, then T is dropped.
                        stk_we    = 1'b1;
                        stk_waddr = STACK_AW'(sp_q - SP_W'(2));
                        stk_wdata = (op == OP_ADD) ? (s_data + t_data) : (s_data - t_data);
                        sp_d      = sp_q - SP_W'(1);
                    end
                    OP_JMPF: pc_d = pc_inc + imm_pc;
                    OP_JMPB: pc_d = pc_inc - imm_pc;
                    OP_BEQ, OP_BNE, OP_BLE, OP_BGT: begin
                        sp_d = sp_q - SP_W'(2);
                        if (br_taken) begin
                            pc_d = pc_inc + imm_pc;
                        end
                    end
                    OP_DUP: begin
                        stk_we    = 1'b1;
                        stk_waddr = STACK_AW'(sp_q);
                        stk_wdata = t_data;
                        sp_d      = sp_q + SP_W'(1);
                    end
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALTED;
                    end
                    default: ;
                endcase
            end
        end else if (start) begin
            state_d   = ST_RUN;
            pc_d      = '0;
            sp_d      = '0;
            retired_d = '0;
            err_d     = ERR_NONE;
        end

        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_HALTED);
        error_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            sp_q      <= '0;
            retired_q <= '0;
            err_q     <= ERR_NONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            retired_q <= retired_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Memories hold their contents across reset and restarts.
    always_ff @(posedge clk) begin
        if (imem_we && (state_q != ST_RUN)) begin
            imem[imem_waddr] <= imem_wdata;
        end
        if (dm_we) begin
            dmem[dm_waddr] <= dm_wdata;
        end
    end

    assign dmem_rdata = dmem[dmem_raddr];
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_q;
    assign pc_o       = pc_q;
    assign retired    = retired_q;
    assign tos        = (sp_q == '0) ? '0 : t_data;

endmodule

// File: tb/tb_stack_cpu.sv
// tb/tb_stack_cpu.sv - directed and random programs checked against an interpreter model
module tb_stack_cpu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [11:0] imem_wdata;
    logic [7:0]  dmem_raddr;
    logic [15:0] dmem_rdata;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [7:0]  pc_o;
    logic [15:0] tos;
    logic [15:0] retired;

    int compared;
    int mismatched;
    int cyc;
    int imem_m [0:255];
    int m_dmem [0:255];
    int m_err, m_pc, m_tos, m_retired, m_steps, m_halted;
    int prog [$];
    int n, k, w;

    stack_cpu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .dmem_raddr (dmem_raddr),
        .dmem_rdata (dmem_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .pc_o       (pc_o),
        .tos        (tos),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mk(input int op, input int imm);
        return op * 256 + imm;
    endfunction

    task automatic put(input int addr, input int word);
        imem_we    = 1'b1;
        imem_waddr = 8'(addr);
        imem_wdata = 12'(word);
        imem_m[addr] = word;
        tick();
        imem_we = 1'b0;
    endtask

    task automatic load_prog(input int p [$]);
        for (int i = 0; i < 64; i++) begin
            put(i, (i < p.size()) ? p[i] : mk(12, 0));
        end
    endtask

    // Interpreter: stack as a queue, memories as arrays, 16-entry stack limit.
    task automatic model_exec();
        int stk [$];
        int pc, op, imm, need, t, s;
        bit push, taken;
        pc = 0; m_retired = 0; m_err = 0; m_halted = 0; m_steps = 0;
        while (!m_halted && m_err == 0 && m_steps < 1000) begin
            op  = imem_m[pc] / 256;
            imm = imem_m[pc] % 256;
            m_steps++;
            need = (op == 2 || op == 11) ? 1 : ((op == 3 || op == 4 || (op >= 7 && op <= 10)) ? 2 : 0);
            push = (op == 0 || op == 1 || op == 11);
            if (op > 12) m_err = 3;
            else if (stk.size() < need) m_err = 1;
            else if (push && stk.size() == 16) m_err = 2;
            else begin
                m_retired++;
                t = (stk.size() > 0) ? stk[stk.size()-1] : 0;
                s = (stk.size() > 1) ? stk[stk.size()-2] : 0;
                case (op)
                    0: begin stk.push_back(imm); pc = pc + 1; end
                    1: begin stk.push_back(m_dmem[imm]); pc = pc + 1; end
                    2: begin m_dmem[imm] = t; void'(stk.pop_back()); pc = pc + 1; end
                    3, 4: begin
                        void'(stk.pop_back()); void'(stk.pop_back());
                        stk.push_back((op == 3 ? s + t : s - t) & 16'hFFFF);
                        pc = pc + 1;
                    end
                    5: pc = pc + 1 + imm;
                    6: pc = pc + 1 - imm;
                    7, 8, 9, 10: begin
                        void'(stk.pop_back()); void'(stk.pop_back());
                        taken = (op == 7) ? (s == t) : (op == 8) ? (s != t) : (op == 9) ? (s <= t) : (s > t);
                        pc = pc + 1 + (taken ? imm : 0);
                    end
                    11: begin stk.push_back(t); pc = pc + 1; end
                    default: m_halted = 1;
                endcase
                pc = pc & 255;
            end
        end
        m_pc  = pc;
        m_tos = (stk.size() > 0) ? stk[stk.size()-1] : 0;
    endtask

    // Start (optionally with an imem write on the same edge), wait, compare with the model.
    task automatic run_check(input string tag, input int wr_addr, input int wr_word);
        if (wr_addr >= 0) begin
            imem_we    = 1'b1;
            imem_waddr = 8'(wr_addr);
            imem_wdata = 12'(wr_word);
            imem_m[wr_addr] = wr_word;
        end
        model_exec();
        start = 1'b1;
        tick();
        start   = 1'b0;
        imem_we = 1'b0;
        check({tag, ":busy"}, busy, 1);
        cyc = 0;
        while (!(done || error) && cyc < 500) begin
            tick();
            cyc++;
        end
        check({tag, ":cycles"}, cyc, m_steps);
        check({tag, ":done"}, done, m_halted);
        check({tag, ":error"}, error, (m_err != 0));
        check({tag, ":err_code"}, err_code, m_err);
        check({tag, ":pc"}, pc_o, m_pc);
        check({tag, ":tos"}, tos, m_tos);
        check({tag, ":retired"}, retired, m_retired);
        for (int a = 0; a < 8; a++) begin
            dmem_raddr = 8'(a);
            #1;
            check($sformatf("%s:dmem%0d", tag, a), dmem_rdata, m_dmem[a]);
        end
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst_n = 1'b1; start = 1'b0; imem_we = 1'b0;
        imem_waddr = '0; imem_wdata = '0; dmem_raddr = '0;
        for (int i = 0; i < 256; i++) begin imem_m[i] = 0; m_dmem[i] = 0; end
        tick(); tick();
        rst_n = 1'b0;
        tick();

        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:error", error, 0);
        check("reset:err_code", err_code, 0);
        check("reset:pc", pc_o, 0);
        check("reset:tos", tos, 0);
        check("reset:retired", retired, 0);

        prog.delete();
        for (int a = 0; a < 8; a++) begin
            prog.push_back(mk(0, (a * 37 + 11) & 255));
            prog.push_back(mk(2, a));
        end
        load_prog(prog);
        run_check("init", -1, 0);

        prog = '{mk(0, 3), mk(0, 4), mk(3, 0), mk(2, 5), mk(12, 0)};
        load_prog(prog);
        run_check("addst", -1, 0);
        check("addst:cycles5", cyc, 5);
        check("addst:retired5", retired, 5);
        dmem_raddr = 8'd5; #1;
        check("addst:dmem5", dmem_rdata, 7);

        prog = '{mk(0, 5), mk(0, 5), mk(7, 1), mk(0, 9), mk(12, 0)};
        load_prog(prog);
        run_check("beq_t", -1, 0);
        check("beq_t:pc", pc_o, 4);
        check("beq_t:tos", tos, 0);
        check("beq_t:retired", retired, 4);

        prog = '{mk(0, 5), mk(0, 6), mk(7, 1), mk(0, 9), mk(12, 0)};
        load_prog(prog);
        run_check("beq_nt", -1, 0);
        check("beq_nt:tos", tos, 9);
        check("beq_nt:retired", retired, 5);

        prog = '{mk(3, 0)};
        load_prog(prog);
        run_check("under", -1, 0);
        check("under:err_code", err_code, 1);
        check("under:pc", pc_o, 0);
        check("under:retired", retired, 0);

        prog = '{mk(15, 0)};
        load_prog(prog);
        run_check("illegal", -1, 0);
        check("illegal:err_code", err_code, 3);

        prog.delete();
        for (int i = 1; i <= 17; i++) prog.push_back(mk(0, i));
        load_prog(prog);
        run_check("over", -1, 0);
        check("over:err_code", err_code, 2);
        check("over:pc", pc_o, 16);
        check("over:tos", tos, 16);
        check("over:retired", retired, 16);

        // Infinite loop, write lockout, asynchronous abort.
        prog = '{mk(6, 1)};
        load_prog(prog);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("loop:busy", busy, 1);
        check("loop:pc", pc_o, 0);
        imem_we = 1'b1; imem_waddr = 8'd0; imem_wdata = 12'(mk(12, 0));
        tick();
        imem_we = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("lock:busy", busy, 1);
        check("lock:retired", retired, 9);
        #2;
        rst_n = 1'b1;
        #1;
        check("abort:busy", busy, 0);
        check("abort:retired", retired, 0);
        rst_n = 1'b0;
        run_check("restart", 0, mk(12, 0));
        check("restart:done", done, 1);
        check("restart:retired", retired, 1);

        for (int r = 0; r < 30; r++) begin
            prog.delete();
            n = $urandom_range(3, 18);
            if (r % 4 != 0) begin
                prog.push_back(mk(0, $urandom_range(0, 255)));
                prog.push_back(mk(0, $urandom_range(0, 255)));
            end
            for (int i = 0; i < n; i++) begin
                k = $urandom_range(0, 99);
                if (k < 25)      w = mk(0, $urandom_range(0, 255));
                else if (k < 35) w = mk(1, $urandom_range(0, 7));
                else if (k < 43) w = mk(2, $urandom_range(0, 7));
                else if (k < 55) w = mk(3, 0);
                else if (k < 63) w = mk(4, 0);
                else if (k < 68) w = mk(5, $urandom_range(0, 5));
                else if (k < 80) w = mk($urandom_range(7, 10), $urandom_range(0, 5));
                else if (k < 90) w = mk(11, 0);
                else if (k < 94) w = mk($urandom_range(13, 15), 0);
                else             w = mk(12, 0);
                prog.push_back(w);
            end
            load_prog(prog);
            run_check($sformatf("rnd%0d", r), -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
